gray_codec: RTL
===============

GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous counter clear, active-high.
REQ-005 mode  input  2  operation select: 00 = binary-to-Gray, 01 = Gray-to-binary, 10 = count up, 11 = count down.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block can accept an input beat this cycle.
REQ-008 in_data  input  WIDTH  operand (ignored in modes 10/11).
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts the output beat.
REQ-011 out_data  output  WIDTH  result: Gray code in modes 00/10/11, binary in mode 01.
REQ-012 out_bin  output  WIDTH  binary value represented by out_data.
REQ-013 wrap  output  1  counter wrapped on this beat (modes 10/11 only).

Function
REQ-014 Accept = in_valid && in_ready; mode and in_data are sampled only on accept.
REQ-015 in_ready = !clr && (!out_valid || out_ready), combinational.
REQ-016 Latency is exactly 1 cycle: an accepted beat appears on out_data/out_bin/wrap with out_valid=1 after the next rising edge.
REQ-017 Output register loads only on accept; out_data/out_bin/wrap hold stable while out_valid && !out_ready.
REQ-018 out_valid sets on accept and clears after an edge where out_ready=1 and no accept occurs.
REQ-019 Mode 00: out_data[WIDTH-1] = in_data[WIDTH-1]; out_data[i] = in_data[i+1] XOR in_data[i] for i < WIDTH-1; out_bin = in_data.
REQ-020 Mode 01: out_data[WIDTH-1] = in_data[WIDTH-1]; out_data[i] = out_data[i+1] XOR in_data[i] (prefix XOR from MSB); out_bin = out_data.
REQ-021 Modes 00/01: wrap = 0; internal counter unchanged.
REQ-022 Internal counter cnt, WIDTH bits, binary, modulo 2^WIDTH.
REQ-023 Mode 10 accept: cnt <= cnt+1; out_bin = cnt+1; out_data = Gray(cnt+1); wrap = 1 iff old cnt = all-ones.
REQ-024 Mode 11 accept: cnt <= cnt-1; out_bin = cnt-1; out_data = Gray(cnt-1); wrap = 1 iff old cnt = 0.
REQ-025 Consecutive counter outputs differ in exactly one out_data bit, including across wrap.
REQ-026 clr=1: cnt <= 0 on the edge; no accept that cycle (in_ready=0); a pending output beat is unaffected and drains normally.
REQ-027 Mode changes between beats are legal; cnt retains its value across conversion-mode beats.
REQ-028 No combinational path from in_valid/in_data/mode to any output; out_ready-to-in_ready is the only combinational path.

Reset
REQ-029 rst_n=0 asynchronously forces out_valid=0, out_data=0, out_bin=0, wrap=0, cnt=0, regardless of clk.
REQ-030 A beat in flight at reset assertion is discarded; no output beat follows reset release without a new accept.
REQ-031 While rst_n=0, in_ready = 0.

Verification
REQ-032 WIDTH=4, mode 00, in_data=1010, out_ready=1 -> next cycle out_valid=1, out_data=1111, out_bin=1010, wrap=0.
REQ-033 WIDTH=4, mode 01, in_data=1000 -> out_data=1111, out_bin=1111; in_data=0110 -> out_data=0100.
REQ-034 WIDTH=4, after reset, 16 back-to-back mode-10 beats -> out_data 0001,0011,0010,0110,...,1000,0000; wrap=1 only on the 16th beat; one bit change per beat.
REQ-035 After reset, one mode-11 beat -> out_bin=1111, out_data=1000, wrap=1; then clr pulse plus mode-10 beat -> out_bin=0001, wrap=0.
REQ-036 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs frozen, cnt not advanced; out_ready=1 -> held beat transfers, next beat accepted the same cycle (full throughput).
REQ-037 rst_n asserted mid-run with out_valid=1 in counter mode -> outputs and cnt 0 immediately; after release, first mode-10 beat yields out_bin=0001.

Source files
------------

// File: rtl/gray_codec.sv
// Gray code converter and up/down Gray counter with a single-entry
// valid/ready output register (one cycle latency, full throughput).
module gray_codec #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_bin,
    output logic             wrap
);

    localparam logic [1:0] MODE_B2G  = 2'b00;
    localparam logic [1:0] MODE_G2B  = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    logic             vld_q,  vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] bin_q,  bin_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] cnt_q,  cnt_d;
    logic             accept;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] cnt_dec;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Ready depends only on registered state, clr, reset and out_ready, so
    // in_valid/in_data/mode never reach an output combinationally.
    assign in_ready = rst_n && !clr && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_dec  = cnt_q - 1'b1;

    // Next-state for the output register and the counter.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        bin_d  = bin_q;
        wrap_d = wrap_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end
        if (accept) begin
            vld_d = 1'b1;
            unique case (mode)
                MODE_B2G: begin
                    data_d = bin2gray(in_data);
                    bin_d  = in_data;
                    wrap_d = 1'b0;
                end
                MODE_G2B: begin
                    data_d = gray2bin(in_data);
                    bin_d  = gray2bin(in_data);
                    wrap_d = 1'b0;
                end
                MODE_UP: begin
                    cnt_d  = cnt_inc;
                    data_d = bin2gray(cnt_inc);
                    bin_d  = cnt_inc;
                    wrap_d = &cnt_q;
                end
                MODE_DOWN: begin
                    cnt_d  = cnt_dec;
                    data_d = bin2gray(cnt_dec);
                    bin_d  = cnt_dec;
                    wrap_d = (cnt_q == '0);
                end
                default: ;
            endcase
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // State registers; reset discards any beat in flight and the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            bin_q  <= '0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            bin_q  <= bin_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_bin   = bin_q;
    assign wrap      = wrap_q;

endmodule
